serializer_10b_tx: RTL and testbench

- Parallel-to-serial stage directly downstream of the 8b/10b encoder in the PHY transmit path.
- Accepts one encoded 10-bit symbol at a time through a valid/ready handshake into a one-deep holding register, then shifts it out one bit per CLK, bit 'a' first.
- When no symbol is waiting at a symbol boundary, it fills the line with K28.5 idles that alternate RD-/RD+, so the stream stays disparity-neutral.
- Reports symbol boundaries, idle-fill status and a saturating underflow count.

---
 rtl/serializer_10b_tx.sv | 128 ++++++++++++
 tb/tb_serializer_10b_tx.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serializer_10b_tx.sv
// rtl/serializer_10b_tx.sv - 10-bit symbol serializer with alternating K28.5 idle fill
module serializer_10b_tx #(
    parameter int               SYM_W    = 10,
    parameter logic [SYM_W-1:0] IDLE_NEG = 10'h17C,
    parameter logic [SYM_W-1:0] IDLE_POS = 10'h283,
    parameter int               UF_W     = 8
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             enable,
    input  logic [SYM_W-1:0] sym_in,
    input  logic             sym_valid,
    output logic             sym_ready,
    output logic             tx_bit,
    output logic             tx_sym_start,
    output logic             tx_idle,
    output logic [UF_W-1:0]  underflow_cnt
);
    localparam int               CNT_W    = (SYM_W > 1) ? $clog2(SYM_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SYM_W - 1);

    typedef enum logic {
        OFF = 1'b0,
        RUN = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SYM_W-1:0] shreg;
    logic [SYM_W-1:0] hold;
    logic [CNT_W-1:0] bit_cnt;
    logic             hold_full;
    logic             idle_sel;      // 0 = next idle is RD-, 1 = next idle is RD+
    logic             link_started;  // set by the first data symbol; gates underflow counting
    logic             load_now;
    logic             xfer;
    logic             at_last;

    assign at_last = (bit_cnt == LAST_BIT);
    assign tx_bit  = shreg[0];

    // The hold register frees up on the same edge it is loaded into shreg,
    // so a new symbol may enter then (pass-through). sym_valid is not used here.
    assign sym_ready = !hold_full || load_now;
    assign xfer      = sym_valid && sym_ready;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state <= OFF;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_now  = 1'b0;
        case (state)
            OFF: begin
                if (enable) begin
                    load_now  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // enable is only acted on at a symbol boundary so a symbol is never cut short
                if (at_last) begin
                    if (enable) begin
                        load_now = 1'b1;
                    end else begin
                        state_nxt = OFF;
                    end
                end
            end
            default: state_nxt = OFF;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            shreg         <= '0;
            hold          <= '0;
            bit_cnt       <= '0;
            hold_full     <= 1'b0;
            idle_sel      <= 1'b0;
            link_started  <= 1'b0;
            underflow_cnt <= '0;
            tx_sym_start  <= 1'b0;
            tx_idle       <= 1'b0;
        end else begin
            if (xfer) begin
                hold      <= sym_in;
                hold_full <= 1'b1;
            end else if (load_now) begin
                hold_full <= 1'b0;
            end

            if (load_now) begin
                bit_cnt      <= '0;
                tx_sym_start <= 1'b1;
                if (hold_full) begin
                    shreg        <= hold;
                    tx_idle      <= 1'b0;
                    link_started <= 1'b1;
                end else begin
                    shreg    <= idle_sel ? IDLE_POS : IDLE_NEG;
                    idle_sel <= !idle_sel;
                    tx_idle  <= 1'b1;
                    if (link_started && (underflow_cnt != '1)) begin
                        underflow_cnt <= underflow_cnt + UF_W'(1);
                    end
                end
            end else if (state == RUN) begin
                if (!at_last) begin
                    shreg        <= shreg >> 1;
                    bit_cnt      <= bit_cnt + CNT_W'(1);
                    tx_sym_start <= 1'b0;
                end else begin
                    // stopping: line goes quiet, held symbol waits for the next start
                    shreg        <= '0;
                    bit_cnt      <= '0;
                    tx_idle      <= 1'b0;
                    tx_sym_start <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_serializer_10b_tx.sv
// tb/tb_serializer_10b_tx.sv - self-checking bench for serializer_10b_tx
module tb_serializer_10b_tx;
    localparam int         SYM_W = 10;
    localparam logic [9:0] K_NEG = 10'h17C;
    localparam logic [9:0] K_POS = 10'h283;

    logic       CLK       = 1'b0;
    logic       reset     = 1'b0;
    logic       enable    = 1'b0;
    logic       sym_valid = 1'b0;
    logic [9:0] sym_in    = '0;
    logic       sym_ready;
    logic       tx_bit;
    logic       tx_sym_start;
    logic       tx_idle;
    logic [7:0] underflow_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    serializer_10b_tx dut (
        .CLK          (CLK),
        .reset        (reset),
        .enable       (enable),
        .sym_in       (sym_in),
        .sym_valid    (sym_valid),
        .sym_ready    (sym_ready),
        .tx_bit       (tx_bit),
        .tx_sym_start (tx_sym_start),
        .tx_idle      (tx_idle),
        .underflow_cnt(underflow_cnt)
    );

    always #5 CLK = ~CLK;

    // Reference model: a symbol-level view (current symbol + position index,
    // one pending slot, next-idle polarity, saturating idle counter).
    bit         m_run, m_cur_idle, m_pend_full, m_next_pos, m_started;
    int         m_pos, m_uf, m_acc_cnt;
    logic [9:0] m_cur, m_pend;
    logic [9:0] m_acc[$];

    always @(posedge CLK or negedge reset) begin
        bit boundary;
        bit take;
        if (!reset) begin
            m_run = 0; m_pos = 0; m_cur = '0; m_cur_idle = 0; m_pend_full = 0;
            m_next_pos = 0; m_started = 0; m_uf = 0; m_acc.delete();
        end else begin
            boundary = enable && (!m_run || m_pos == SYM_W - 1);
            take = sym_valid && (!m_pend_full || boundary);
            if (boundary) begin
                if (m_pend_full) begin
                    m_cur = m_pend; m_cur_idle = 0; m_started = 1; m_pend_full = 0;
                end else begin
                    m_cur = m_next_pos ? K_POS : K_NEG;
                    m_next_pos = !m_next_pos;
                    m_cur_idle = 1;
                    if (m_started) m_uf = (m_uf >= 255) ? 255 : m_uf + 1;
                end
                m_run = 1; m_pos = 0;
            end else if (m_run && m_pos < SYM_W - 1) begin
                m_pos++;
            end else if (m_run) begin
                m_run = 0; m_pos = 0;
            end
            if (take) begin
                m_pend = sym_in; m_pend_full = 1; m_acc.push_back(sym_in); m_acc_cnt++;
            end
        end
    end

    logic [11:0] exp_vec;
    always_comb begin
        exp_vec = '0;
        exp_vec[11] = m_run ? m_cur[m_pos] : 1'b0;
        exp_vec[10] = m_run && (m_pos == 0);
        exp_vec[9]  = m_run && m_cur_idle;
        exp_vec[8]  = !m_pend_full || (enable && (!m_run || m_pos == SYM_W - 1));
        exp_vec[7:0] = 8'(m_uf);
    end
    wire [11:0] dut_vec = {tx_bit, tx_sym_start, tx_idle, sym_ready, underflow_cnt};

    // Output monitor: rebuilds whole symbols from the serial line.
    logic [9:0] mon_sh;
    int         mon_n = 0;
    bit         mon_idle;
    logic [9:0] dut_syms[$];
    logic [9:0] dut_idles[$];

    always @(negedge CLK or negedge reset) begin
        if (!reset) begin
            mon_n = 0; dut_syms.delete(); dut_idles.delete();
        end else begin
            if (tx_sym_start) begin
                mon_sh = '0; mon_sh[0] = tx_bit; mon_n = 1; mon_idle = tx_idle;
            end else if (mon_n > 0 && mon_n < SYM_W) begin
                mon_sh[mon_n] = tx_bit; mon_n++;
            end
            if (mon_n == SYM_W) begin
                if (mon_idle) dut_idles.push_back(mon_sh);
                else dut_syms.push_back(mon_sh);
                mon_n = 0;
            end
        end
    end

    task automatic test_reset();
        reset = 0; enable = 0; sym_valid = 0;
        #160;
        n_checks++;
        if ({tx_bit, tx_sym_start, tx_idle} !== 3'b000) begin
            n_fail++; $display("FAIL reset_outputs: got %b want 000", {tx_bit, tx_sym_start, tx_idle});
        end
        n_checks++;
        if (underflow_cnt !== 8'd0) begin
            n_fail++; $display("FAIL reset_uf: got %0d want 0", underflow_cnt);
        end
        n_checks++;
        if (sym_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b want 1", sym_ready);
        end
        @(negedge CLK);
        reset = 1;
    endtask

    task automatic test_idle_fill();
        logic [39:0] pat;
        pat = {K_POS, K_NEG, K_POS, K_NEG};
        enable = 1; sym_valid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++; $display("FAIL idle_model c%0d: got %h want %h", i, dut_vec, exp_vec);
            end
            n_checks++;
            if ({tx_bit, tx_sym_start, tx_idle, underflow_cnt} !== {pat[i], (i % 10 == 0), 1'b1, 8'd0}) begin
                n_fail++; $display("FAIL idle_pattern c%0d: got %b/%b/%b/%0d want %b/%b/1/0",
                                   i, tx_bit, tx_sym_start, tx_idle, underflow_cnt, pat[i], (i % 10 == 0));
            end
        end
        enable = 0;
    endtask

    task automatic test_data();
        logic [9:0] d;
        d = 10'h2A5;
        @(negedge CLK);
        n_checks++;
        if ({tx_bit, tx_idle, tx_sym_start} !== 3'b000 || dut_vec !== exp_vec) begin
            n_fail++; $display("FAIL data_off: got %h want %h", dut_vec, exp_vec);
        end
        sym_in = d; sym_valid = 1;
        @(negedge CLK);
        sym_valid = 0;
        n_checks++;
        if ({tx_bit, sym_ready} !== 2'b00) begin
            n_fail++; $display("FAIL data_held_off: got bit=%b ready=%b want 0 0", tx_bit, sym_ready);
        end
        enable = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            n_checks++;
            if (dut_vec !== exp_vec || tx_bit !== d[i] || tx_idle !== 1'b0) begin
                n_fail++; $display("FAIL data_bit%0d: got %h (bit %b) want %h (bit %b)", i, dut_vec, tx_bit, exp_vec, d[i]);
            end
        end
        @(negedge CLK);
        n_checks++;
        if ({tx_bit, tx_sym_start, tx_idle, underflow_cnt} !== {K_NEG[0], 1'b1, 1'b1, 8'd1}) begin
            n_fail++; $display("FAIL data_next_idle: got %b/%b/%b/%0d want 0/1/1/1", tx_bit, tx_sym_start, tx_idle, underflow_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0]  list [3];
        logic [29:0] exp_s;
        logic [29:0] got_s;
        int base, idx, ready_hi, got;
        bit cap;
        list[0] = 10'h21C; list[1] = 10'h2B5; list[2] = 10'h1E3;
        exp_s = {10'h1E3, 10'h2B5, 10'h21C};
        got_s = '0; base = m_acc_cnt; ready_hi = 0; got = 0; cap = 0;
        for (int c = 0; c < 60; c++) begin
            idx = m_acc_cnt - base;
            if (idx < 3) begin sym_in = list[idx]; sym_valid = 1; end
            else sym_valid = 0;
            #1;
            if (sym_valid && sym_ready) ready_hi++;
            @(negedge CLK);
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++; $display("FAIL b2b_model c%0d: got %h want %h", c, dut_vec, exp_vec);
            end
            if (tx_sym_start && !tx_idle) cap = 1;
            if (cap && got < 30) begin got_s[got] = tx_bit; got++; end
        end
        n_checks++;
        if (ready_hi !== 3 || (m_acc_cnt - base) !== 3) begin
            n_fail++; $display("FAIL b2b_ready: got %0d ready pulses, %0d accepted want 3", ready_hi, m_acc_cnt - base);
        end
        n_checks++;
        if (got !== 30 || got_s !== exp_s) begin
            n_fail++; $display("FAIL b2b_stream: got %h (%0d bits) want %h", got_s, got, exp_s);
        end
    endtask

    task automatic test_backpressure();
        logic [9:0] a, b;
        int cnt, n;
        a = 10'($urandom); b = 10'($urandom);
        cnt = 0;
        while (!(m_run && m_pos == SYM_W - 1 && !m_pend_full) && cnt < 40) begin
            @(negedge CLK); cnt++;
        end
        n_checks++;
        if (cnt >= 40) begin n_fail++; $display("FAIL bp_wait: got timeout want boundary"); end
        sym_in = a; sym_valid = 1;
        @(negedge CLK);
        sym_in = b;
        cnt = 0;
        while (!sym_ready && cnt < 20) begin
            @(negedge CLK); cnt++;
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++; $display("FAIL bp_model c%0d: got %h want %h", cnt, dut_vec, exp_vec);
            end
        end
        n_checks++;
        if (cnt !== 9) begin n_fail++; $display("FAIL bp_stall: got %0d stall cycles want 9", cnt); end
        @(negedge CLK);
        sym_valid = 0;
        repeat (25) @(negedge CLK);
        n = dut_syms.size();
        n_checks++;
        if (n < 2 || dut_syms[n-2] !== a || dut_syms[n-1] !== b) begin
            n_fail++; $display("FAIL bp_order: got %0d syms last %h want ..%h %h", n, (n > 0) ? dut_syms[n-1] : 10'h0, a, b);
        end
    endtask

    task automatic test_stop_restart();
        logic [9:0] c, d;
        int cnt, n;
        c = 10'($urandom); d = 10'($urandom);
        cnt = 0;
        while (!(m_run && m_pos == SYM_W - 1 && !m_pend_full) && cnt < 40) begin
            @(negedge CLK); cnt++;
        end
        sym_in = c; sym_valid = 1;
        @(negedge CLK);
        sym_in = d;
        cnt = 0;
        while (!sym_ready && cnt < 20) begin @(negedge CLK); cnt++; end
        @(negedge CLK);
        sym_valid = 0;
        for (int p = 0; p < 10; p++) begin
            if (p > 0) @(negedge CLK);
            if (p == 3) enable = 0;
            n_checks++;
            if (dut_vec !== exp_vec || tx_bit !== c[p]) begin
                n_fail++; $display("FAIL stop_bit%0d: got %h (bit %b) want %h (bit %b)", p, dut_vec, tx_bit, exp_vec, c[p]);
            end
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            n_checks++;
            if ({tx_bit, tx_sym_start, tx_idle, sym_ready} !== 4'b0000) begin
                n_fail++; $display("FAIL stop_off%0d: got %b want 0000", k, {tx_bit, tx_sym_start, tx_idle, sym_ready});
            end
        end
        n = dut_syms.size();
        n_checks++;
        if (n < 1 || dut_syms[n-1] !== c) begin
            n_fail++; $display("FAIL stop_complete: got %h want %h", (n > 0) ? dut_syms[n-1] : 10'h0, c);
        end
        enable = 1;
        @(negedge CLK);
        n_checks++;
        if ({tx_bit, tx_sym_start, tx_idle} !== {d[0], 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL restart: got %b want %b10", {tx_bit, tx_sym_start, tx_idle}, d[0]);
        end
        repeat (12) @(negedge CLK);
        n = dut_syms.size();
        n_checks++;
        if (dut_syms[n-1] !== d) begin
            n_fail++; $display("FAIL restart_sym: got %h want %h", dut_syms[n-1], d);
        end
    endtask

    task automatic test_reset_mid();
        int cnt;
        cnt = 0;
        while (!(m_run && m_pos == 5) && cnt < 40) begin @(negedge CLK); cnt++; end
        #2 reset = 0;
        #1;
        n_checks++;
        if ({tx_bit, tx_sym_start, tx_idle, underflow_cnt, sym_ready} !== {3'b000, 8'd0, 1'b1}) begin
            n_fail++; $display("FAIL reset_mid: got %b/%b/%b/%0d/%b want 0/0/0/0/1",
                               tx_bit, tx_sym_start, tx_idle, underflow_cnt, sym_ready);
        end
        @(negedge CLK);
        reset = 1;
    endtask

    task automatic test_saturation();
        enable = 1; sym_in = 10'($urandom); sym_valid = 1;
        @(negedge CLK);
        sym_valid = 0;
        for (int c = 0; c < 3010; c++) begin
            @(negedge CLK);
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++; $display("FAIL sat_model c%0d: got %h want %h", c, dut_vec, exp_vec);
            end
        end
        n_checks++;
        if (underflow_cnt !== 8'd255) begin
            n_fail++; $display("FAIL sat_value: got %0d want 255", underflow_cnt);
        end
    endtask

    task automatic test_random();
        int last_acc;
        enable = 1; sym_valid = 0;
        last_acc = m_acc_cnt;
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++; $display("FAIL rand_model c%0d: got %h want %h", c, dut_vec, exp_vec);
            end
            if (!sym_valid || m_acc_cnt != last_acc) begin
                sym_valid = ($urandom_range(0, 3) != 0);
                sym_in = 10'($urandom);
            end
            last_acc = m_acc_cnt;
            if ($urandom_range(0, 49) == 0) enable = !enable;
        end
        enable = 1; sym_valid = 0;
        repeat (30) @(negedge CLK);
        n_checks++;
        if (dut_syms.size() !== m_acc.size()) begin
            n_fail++; $display("FAIL rand_count: got %0d syms want %0d", dut_syms.size(), m_acc.size());
        end
        for (int i = 0; i < dut_syms.size() && i < m_acc.size(); i++) begin
            n_checks++;
            if (dut_syms[i] !== m_acc[i]) begin
                n_fail++; $display("FAIL rand_sym%0d: got %h want %h", i, dut_syms[i], m_acc[i]);
            end
        end
        for (int i = 0; i < dut_idles.size(); i++) begin
            n_checks++;
            if (dut_idles[i] !== ((i % 2 == 0) ? K_NEG : K_POS)) begin
                n_fail++; $display("FAIL idle_alt%0d: got %h want %h", i, dut_idles[i], (i % 2 == 0) ? K_NEG : K_POS);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_fill();
        test_data();
        test_back_to_back();
        test_backpressure();
        test_stop_restart();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
